biquad_cascade_stream: RTL and testbench



---
 rtl/biquad_cascade_stream_if.sv | 26 ++
 rtl/biquad_cascade_stream.sv | 233 +++++++++++++++++++++++
 tb/tb_biquad_cascade_stream.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biquad_cascade_stream_if.sv
// Sample stream and coefficient/control register port of the biquad cascade engine.
// The engine takes the slave view; whoever feeds samples and coefficients takes the master view.
interface biquad_cascade_stream_if #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     cfg_write;
    logic [7:0]               cfg_address;
    logic [COEFF_W-1:0]       cfg_writedata;

    modport slave (
        input  in_valid, in_data, out_ready, cfg_write, cfg_address, cfg_writedata,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready, cfg_write, cfg_address, cfg_writedata,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/biquad_cascade_stream.sv
// Time-multiplexed Direct Form I biquad cascade: one shared MAC evaluates five taps per section,
// then rounds, saturates and feeds the next section. Coefficients are double-buffered.
module biquad_cascade_stream #(
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 32,
    parameter int COEFF_FRAC = 30,
    parameter int SECTIONS   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    biquad_cascade_stream_if.slave bus,
    output logic                   busy,
    output logic                   sat_flag
);
    localparam int ACC_W  = DATA_W + COEFF_W + 3;
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int SW     = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int NS     = 1 << SW;

    localparam logic signed [ACC_W-1:0]   ROUND_C   = ACC_W'(1) << (COEFF_FRAC - 1);
    localparam logic signed [ACC_W-1:0]   SAT_MAX   = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]   SAT_MIN   = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0]  DATA_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0]  DATA_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [COEFF_W-1:0] COEF_ONE  = COEFF_W'(1) << COEFF_FRAC;
    localparam logic [SW-1:0]             LAST_SECT = SW'(SECTIONS - 1);
    localparam logic [4:0]                SECT_LIM  = 5'(SECTIONS);

    typedef enum logic [1:0] {IDLE, MAC, SCALE} state_t;

    state_t                     state_q, state_d;
    logic [SW-1:0]              sect_q, sect_d;
    logic [2:0]                 tap_q, tap_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   x_q, x_d;
    logic                       outValid_q, outValid_d;
    logic signed [DATA_W-1:0]   outData_q, outData_d;
    logic                       sat_q, sat_d;
    logic                       bypass_q, bypass_d;
    logic                       bypassRun_q, bypassRun_d;
    logic                       commitPend_q, commitPend_d;
    logic                       clrHistPend_q, clrHistPend_d;

    logic signed [COEFF_W-1:0]  coefShd_q [NS][5];
    logic signed [COEFF_W-1:0]  coefAct_q [NS][5];
    logic signed [DATA_W-1:0]   x1_q [NS];
    logic signed [DATA_W-1:0]   x2_q [NS];
    logic signed [DATA_W-1:0]   y1_q [NS];
    logic signed [DATA_W-1:0]   y2_q [NS];

    logic [4:0]                 wrSect;
    logic [2:0]                 wrTap;
    logic                       ctrlWr, coefWr, inReady, accept;
    logic                       commitApply, clrApply, histWe, satEvent, clamp;
    logic signed [DATA_W-1:0]   operand, satVal;
    logic signed [COEFF_W-1:0]  coef;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    productExt, accRnd, shifted;

    assign wrSect      = bus.cfg_address[7:3];
    assign wrTap       = bus.cfg_address[2:0];
    assign ctrlWr      = bus.cfg_write && (bus.cfg_address == 8'hFF);
    assign coefWr      = bus.cfg_write && (wrSect < SECT_LIM) && (wrTap <= 3'd4);
    assign inReady     = (state_q == IDLE) && !outValid_q && !reset;
    assign accept      = bus.in_valid && inReady;
    assign commitApply = commitPend_q && (state_q == IDLE);
    assign clrApply    = clrHistPend_q && (state_q == IDLE);

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign busy          = (state_q != IDLE);
    assign sat_flag      = sat_q;

    // Tap t of the current section pairs coefficient t with x, x1, x2, y1, y2 in that order.
    always_comb begin
        operand = x_q;
        coef    = coefAct_q[sect_q][0];
        case (tap_q)
            3'd1: begin operand = x1_q[sect_q]; coef = coefAct_q[sect_q][1]; end
            3'd2: begin operand = x2_q[sect_q]; coef = coefAct_q[sect_q][2]; end
            3'd3: begin operand = y1_q[sect_q]; coef = coefAct_q[sect_q][3]; end
            3'd4: begin operand = y2_q[sect_q]; coef = coefAct_q[sect_q][4]; end
            default: ;
        endcase
    end

    assign product    = coef * operand;
    assign productExt = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign accRnd     = acc_q + ROUND_C;
    assign shifted    = accRnd >>> COEFF_FRAC;

    always_comb begin
        satVal = shifted[DATA_W-1:0];
        clamp  = 1'b0;
        if (shifted > SAT_MAX) begin
            satVal = DATA_MAX;
            clamp  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            satVal = DATA_MIN;
            clamp  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sect_d      = sect_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        x_d         = x_q;
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        bypassRun_d = bypassRun_q;
        histWe      = 1'b0;
        satEvent    = 1'b0;
        if (outValid_q && bus.out_ready) outValid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d         = bus.in_data;
                    sect_d      = '0;
                    tap_d       = '0;
                    acc_d       = '0;
                    bypassRun_d = bypass_q;
                    state_d     = bypass_q ? SCALE : MAC;
                end
            end
            MAC: begin
                // Feed-forward taps accumulate, feedback taps (a1, a2) subtract.
                acc_d = (tap_q < 3'd3) ? acc_q + productExt : acc_q - productExt;
                tap_d = tap_q + 3'd1;
                if (tap_q == 3'd4) state_d = SCALE;
            end
            SCALE: begin
                if (bypassRun_q) begin
                    outData_d  = x_q;
                    outValid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    histWe   = 1'b1;
                    satEvent = clamp;
                    x_d      = satVal;
                    acc_d    = '0;
                    tap_d    = '0;
                    if (sect_q == LAST_SECT) begin
                        outData_d  = satVal;
                        outValid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        sect_d  = sect_q + SW'(1);
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control requests stay pending until the engine is idle, so in-flight samples see a stable bank.
    always_comb begin
        bypass_d      = ctrlWr ? bus.cfg_writedata[0] : bypass_q;
        commitPend_d  = (commitPend_q && !commitApply) || (ctrlWr && bus.cfg_writedata[2]);
        clrHistPend_d = (clrHistPend_q && !clrApply) || (ctrlWr && bus.cfg_writedata[1]);
        sat_d         = (sat_q && !(ctrlWr && bus.cfg_writedata[3])) || satEvent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sect_q        <= '0;
            tap_q         <= '0;
            acc_q         <= '0;
            x_q           <= '0;
            outValid_q    <= 1'b0;
            outData_q     <= '0;
            sat_q         <= 1'b0;
            bypass_q      <= 1'b0;
            bypassRun_q   <= 1'b0;
            commitPend_q  <= 1'b0;
            clrHistPend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sect_q        <= sect_d;
            tap_q         <= tap_d;
            acc_q         <= acc_d;
            x_q           <= x_d;
            outValid_q    <= outValid_d;
            outData_q     <= outData_d;
            sat_q         <= sat_d;
            bypass_q      <= bypass_d;
            bypassRun_q   <= bypassRun_d;
            commitPend_q  <= commitPend_d;
            clrHistPend_q <= clrHistPend_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                for (int t = 0; t < 5; t++) begin
                    coefShd_q[s][t] <= (t == 0) ? COEF_ONE : '0;
                    coefAct_q[s][t] <= (t == 0) ? COEF_ONE : '0;
                end
            end
        end else begin
            if (coefWr) coefShd_q[wrSect[SW-1:0]][wrTap] <= bus.cfg_writedata;
            if (commitApply) coefAct_q <= coefShd_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else if (clrApply) begin
            for (int s = 0; s < NS; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else if (histWe) begin
            x2_q[sect_q] <= x1_q[sect_q];
            x1_q[sect_q] <= x_q;
            y2_q[sect_q] <= y1_q[sect_q];
            y1_q[sect_q] <= satVal;
        end
    end
endmodule

// File: tb/tb_biquad_cascade_stream.sv
// Scoreboard bench for biquad_cascade_stream: expected samples come from a plain-arithmetic
// cascade model and are checked by an independent monitor when the engine presents results.
`timescale 1ns/1ps
module tb_biquad_cascade_stream;
    localparam int DATA_W     = 16;
    localparam int COEFF_W    = 32;
    localparam int COEFF_FRAC = 30;
    localparam int SECTIONS   = 2;
    localparam int LAT        = 6 * SECTIONS;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   busy, sat_flag;
    longint cyc = 0;
    int     passCnt = 0;
    int     checkCnt = 0;

    typedef struct {
        int     data;
        longint acceptCyc;
        int     latency;
    } exp_t;
    exp_t expQ[$];

    longint mAct [SECTIONS][5];
    longint mShd [SECTIONS][5];
    longint mX1 [SECTIONS];
    longint mX2 [SECTIONS];
    longint mY1 [SECTIONS];
    longint mY2 [SECTIONS];
    bit     mCommitPend, mClrPend, mBypass, mSat;

    biquad_cascade_stream_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W)) bus ();

    biquad_cascade_stream #(
        .DATA_W(DATA_W), .COEFF_W(COEFF_W), .COEFF_FRAC(COEFF_FRAC), .SECTIONS(SECTIONS)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCnt++;
        if (actual == expected) passCnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic void modelReset();
        for (int s = 0; s < SECTIONS; s++) begin
            for (int t = 0; t < 5; t++) begin
                mAct[s][t] = (t == 0) ? (longint'(1) << COEFF_FRAC) : 0;
                mShd[s][t] = mAct[s][t];
            end
            mX1[s] = 0; mX2[s] = 0; mY1[s] = 0; mY2[s] = 0;
        end
        mCommitPend = 0; mClrPend = 0; mBypass = 0; mSat = 0;
    endfunction

    // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded half up, clamped to the sample range.
    function automatic int modelAccept(input int sample, output int latency);
        longint acc, r, v;
        if (mCommitPend) begin mAct = mShd; mCommitPend = 0; end
        if (mClrPend) begin
            for (int s = 0; s < SECTIONS; s++) begin
                mX1[s] = 0; mX2[s] = 0; mY1[s] = 0; mY2[s] = 0;
            end
            mClrPend = 0;
        end
        if (mBypass) begin
            latency = 1;
            return sample;
        end
        latency = LAT;
        v = sample;
        for (int s = 0; s < SECTIONS; s++) begin
            acc = mAct[s][0] * v + mAct[s][1] * mX1[s] + mAct[s][2] * mX2[s]
                - mAct[s][3] * mY1[s] - mAct[s][4] * mY2[s];
            r = (acc + (longint'(1) << (COEFF_FRAC - 1))) >>> COEFF_FRAC;
            if (r > 32767) begin r = 32767; mSat = 1; end
            else if (r < -32768) begin r = -32768; mSat = 1; end
            mX2[s] = mX1[s]; mX1[s] = v; mY2[s] = mY1[s]; mY1[s] = r;
            v = r;
        end
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeCfg(input logic [7:0] addr, input logic [31:0] data);
        int s, t;
        s = int'(addr[7:3]);
        t = int'(addr[2:0]);
        if (addr == 8'hFF) begin
            mBypass = data[0];
            if (data[1]) mClrPend = 1;
            if (data[2]) mCommitPend = 1;
            if (data[3]) mSat = 0;
        end else if (s < SECTIONS && t <= 4) begin
            mShd[s][t] = longint'($signed(data));
        end
        bus.cfg_write     = 1'b1;
        bus.cfg_address   = addr;
        bus.cfg_writedata = data;
        tick();
        bus.cfg_write = 1'b0;
    endtask

    task automatic writeCoef(input int sect, input int tap, input logic [31:0] data);
        logic [7:0] a;
        a = {sect[4:0], tap[2:0]};
        writeCfg(a, data);
    endtask

    task automatic applyStimulus(input int sample, input bit useConst, input int constExp,
                                 input bit randReady, output longint acceptCyc);
        int   waitCnt;
        bit   done;
        exp_t e;
        waitCnt = 0;
        done = 0;
        acceptCyc = -1;
        bus.in_valid = 1'b1;
        bus.in_data  = sample[DATA_W-1:0];
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1;
                acceptCyc = cyc + 1;
                e.data = modelAccept(sample, e.latency);
                if (useConst) e.data = constExp;
                e.acceptCyc = acceptCyc;
                expQ.push_back(e);
            end else if (++waitCnt > 300) begin
                checkOutput("accept_timeout", longint'(waitCnt), 0);
                done = 1;
            end
            tick();
            if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || bus.out_valid || expQ.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", longint'(expQ.size()), 0);
        @(negedge clk);
        checkOutput("sat_flag", longint'(sat_flag), longint'(mSat));
        tick();
    endtask

    initial begin : monitor
        bit   presented;
        exp_t e;
        presented = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                presented = 0;
            end else begin
                if (bus.out_valid && !presented) begin
                    presented = 1;
                    checkOutput("output_expected", longint'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("out_data", longint'(bus.out_data), longint'(e.data));
                        checkOutput("out_latency", cyc - e.acceptCyc, longint'(e.latency));
                    end
                end
                if (bus.out_valid && bus.out_ready) presented = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks so far %0d", checkCnt);
        $display("%0d/%0d checks passed", passCnt, checkCnt + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        longint ac, c0;
        int     n, v;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus.cfg_write = 1'b0; bus.cfg_address = '0; bus.cfg_writedata = '0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
        checkOutput("rst_in_ready", longint'(bus.in_ready), 0);
        checkOutput("rst_out_data", longint'(bus.out_data), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_sat_flag", longint'(sat_flag), 0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] identity pass-through");
        applyStimulus(100, 1, 100, 0, ac);
        checkOutput("busy_after_accept", longint'(busy), 1);
        applyStimulus(-5, 1, -5, 0, ac);
        waitIdle();

        $display("[TB] b0 = 0.5, half-up rounding");
        writeCoef(0, 0, 32'h2000_0000);
        writeCfg(8'hFF, 32'h4);
        applyStimulus(7, 1, 4, 0, ac);
        applyStimulus(-7, 1, -3, 0, ac);
        waitIdle();

        $display("[TB] b0 = 1.5, saturation");
        writeCoef(0, 0, 32'h6000_0000);
        writeCfg(8'hFF, 32'h4);
        applyStimulus(30000, 1, 32767, 0, ac);
        waitIdle();
        checkOutput("sat_set", longint'(sat_flag), 1);
        writeCfg(8'hFF, 32'h8);
        @(negedge clk);
        checkOutput("sat_cleared", longint'(sat_flag), 0);
        tick();

        $display("[TB] one-pole recursion a1 = -0.5");
        writeCoef(0, 0, 32'h4000_0000);
        writeCoef(0, 3, 32'hE000_0000);
        writeCfg(8'hFF, 32'h6);
        applyStimulus(1000, 1, 1000, 0, ac);
        applyStimulus(0, 1, 500, 0, ac);
        applyStimulus(0, 1, 250, 0, ac);
        applyStimulus(0, 1, 125, 0, ac);
        applyStimulus(0, 1, 63, 0, ac);
        applyStimulus(0, 1, 32, 0, ac);
        waitIdle();
        writeCfg(8'hFF, 32'h2);
        applyStimulus(0, 1, 0, 0, ac);
        waitIdle();
        writeCoef(0, 3, 32'h0);
        writeCfg(8'hFF, 32'h6);

        $display("[TB] bypass");
        writeCfg(8'hFF, 32'h1);
        applyStimulus(1234, 1, 1234, 0, ac);
        applyStimulus(-77, 1, -77, 0, ac);
        waitIdle();
        writeCfg(8'hFF, 32'h0);

        $display("[TB] output backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(555, 1, 555, 0, ac);
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        checkOutput("hold_out_valid_seen", longint'(bus.out_valid), 1);
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd777;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", longint'(bus.out_valid), 1);
            checkOutput("hold_out_data", longint'(bus.out_data), 555);
            checkOutput("hold_in_ready", longint'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        c0 = cyc;
        applyStimulus(777, 1, 777, 0, ac);
        checkOutput("accept_after_release", ac - c0, 2);
        waitIdle();

        $display("[TB] out-of-range register writes");
        writeCfg(8'h10, 32'h1234_5678);
        writeCfg(8'h05, 32'h7FFF_FFFF);
        writeCfg(8'h0F, 32'h7FFF_FFFF);
        writeCfg(8'hFF, 32'h4);
        applyStimulus(1000, 1, 1000, 0, ac);
        waitIdle();

        $display("[TB] commit while busy");
        applyStimulus(200, 1, 200, 0, ac);
        writeCoef(0, 0, 32'h2000_0000);
        writeCfg(8'hFF, 32'h4);
        checkOutput("busy_during_commit", longint'(busy), 1);
        applyStimulus(200, 1, 100, 0, ac);
        waitIdle();

        $display("[TB] reset mid-computation");
        applyStimulus(999, 1, 500, 0, ac);
        repeat (3) tick();
        reset = 1'b1;
        expQ.delete();
        modelReset();
        @(negedge clk);
        checkOutput("midrst_out_valid", longint'(bus.out_valid), 0);
        checkOutput("midrst_busy", longint'(busy), 0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(321, 1, 321, 0, ac);
        waitIdle();

        $display("[TB] randomized coefficients and samples");
        for (int s = 0; s < SECTIONS; s++) begin
            for (int t = 0; t < 5; t++) begin
                v = int'($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000;
                writeCoef(s, t, v);
            end
        end
        writeCfg(8'hFF, 32'h6);
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 65535)) - 32768;
            applyStimulus(v, 0, 0, 1, ac);
            repeat ($urandom_range(0, 3)) tick();
        end
        bus.out_ready = 1'b1;
        waitIdle();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
